// File: rtl/lr35902_bg_fetch.sv
// Background tile fetcher: VRAM map/tile reads, 8-pixel shift buffer, pixel handshake.
// Optional `define BG_DISABLE_EN forces pix to 0 while bg_en is low.
module lr35902_bg_fetch #(
  parameter int LINE_PIXELS = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  ly,
  input  logic [7:0]  scy,
  input  logic [7:0]  scx,
  input  logic        map_sel,
  input  logic        data_sel,
  input  logic        bg_en,
  output logic [12:0] vram_adr,
  output logic        vram_read,
  input  logic        vram_gnt,
  input  logic [7:0]  vram_dout,
  output logic [1:0]  pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        line_done
);

  localparam int CW = $clog2(LINE_PIXELS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP, S_MAP_W, S_LO, S_LO_W, S_HI, S_HI_W, S_PUSH
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      row_q, row_d;
  logic [4:0]      tx_q, tx_d;
  logic [2:0]      disc_q, disc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [7:0]      tile_q, tile_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      sh_lo_q, sh_lo_d;
  logic [7:0]      sh_hi_q, sh_hi_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [12:0] map_a, tile_base, lo_a, hi_a;
  logic        pop_out, pop_int, pop;
  logic [1:0]  raw_pix;

  assign map_a = (map_sel ? 13'h1C00 : 13'h1800)
               + {3'b0, row_q[7:3], 5'b0}
               + {8'b0, tx_q};
  // Signed tile index: 0x1000 + sext(tile)*16, so 0x80 lands on 0x0800
  assign tile_base = data_sel ? {1'b0, tile_q, 4'b0}
                              : 13'h1000 + {tile_q[7], tile_q, 4'b0};
  assign lo_a = tile_base + {9'b0, row_q[2:0], 1'b0};
  assign hi_a = lo_a + 13'd1;

  assign pix_valid = (cnt_q != 4'd0) && (disc_q == 3'd0);
  assign pop_out   = pix_valid && pix_ready;
  assign pop_int   = (cnt_q != 4'd0) && (disc_q != 3'd0);
  assign pop       = pop_out || pop_int;
  assign raw_pix   = {sh_hi_q[7], sh_lo_q[7]};

`ifdef BG_DISABLE_EN
  assign pix = bg_en ? raw_pix : 2'b00;
`else
  logic unused_bg_en;
  assign unused_bg_en = bg_en;
  assign pix = raw_pix;
`endif

  assign busy      = busy_q;
  assign line_done = done_q;

  always_comb begin
    vram_read = 1'b0;
    vram_adr  = 13'd0;
    unique case (state_q)
      S_MAP: begin
        vram_read = 1'b1;
        vram_adr  = map_a;
      end
      S_LO: begin
        vram_read = 1'b1;
        vram_adr  = lo_a;
      end
      S_HI: begin
        vram_read = 1'b1;
        vram_adr  = hi_a;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tx_d    = tx_q;
    disc_d  = disc_q;
    out_d   = out_q;
    tile_d  = tile_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    sh_lo_d = sh_lo_q;
    sh_hi_d = sh_hi_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (pop) begin
      sh_lo_d = {sh_lo_q[6:0], 1'b0};
      sh_hi_d = {sh_hi_q[6:0], 1'b0};
      cnt_d   = cnt_q - 4'd1;
      if (pop_int) disc_d = disc_q - 3'd1;
      if (pop_out) out_d = out_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: ;
      S_MAP:  if (vram_gnt) state_d = S_MAP_W;
      S_MAP_W: begin
        tile_d  = vram_dout;
        tx_d    = tx_q + 5'd1;
        state_d = S_LO;
      end
      S_LO:   if (vram_gnt) state_d = S_LO_W;
      S_LO_W: begin
        lo_d    = vram_dout;
        state_d = S_HI;
      end
      S_HI:   if (vram_gnt) state_d = S_HI_W;
      S_HI_W: begin
        hi_d    = vram_dout;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        // Refill only once the last buffered pixel leaves this cycle
        if (cnt_q == 4'd0 || (cnt_q == 4'd1 && pop)) begin
          sh_lo_d = lo_q;
          sh_hi_d = hi_q;
          cnt_d   = 4'd8;
          state_d = S_MAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_out && out_q == CW'(LINE_PIXELS - 1)) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
      state_d = S_IDLE;
    end

    if (line_start) begin
      state_d = S_MAP;
      row_d   = ly + scy;
      tx_d    = scx[7:3];
      disc_d  = scx[2:0];
      out_d   = '0;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= 8'd0;
      tx_q    <= 5'd0;
      disc_q  <= 3'd0;
      out_q   <= '0;
      tile_q  <= 8'd0;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      sh_lo_q <= 8'd0;
      sh_hi_q <= 8'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tx_q    <= tx_d;
      disc_q  <= disc_d;
      out_q   <= out_d;
      tile_q  <= tile_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sh_lo_q <= sh_lo_d;
      sh_hi_q <= sh_hi_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lr35902_bg_fetch.sv
// Directed bench for lr35902_bg_fetch: VRAM model, per-pixel reference, handshake checks.
// Pixel expectations come from a direct tile-map walk over the bench's VRAM image.
module tb_lr35902_bg_fetch;

  localparam int LP = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  ly = 8'd0;
  logic [7:0]  scy = 8'd0;
  logic [7:0]  scx = 8'd0;
  logic        map_sel = 1'b0;
  logic        data_sel = 1'b1;
  logic        bg_en = 1'b1;
  logic [12:0] vram_adr;
  logic        vram_read;
  logic        vram_gnt = 1'b1;
  logic [7:0]  vram_dout = 8'd0;
  logic [1:0]  pix;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        busy;
  logic        line_done;

  logic [7:0]  mem [0:8191];
  logic [12:0] rd_log [$];
  logic [1:0]  got [0:LP-1];
  int          ld_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          bg_zero = 1'b0;
  int          first_v;

  lr35902_bg_fetch #(.LINE_PIXELS(LP)) dut (
    .clk(clk), .reset(reset), .line_start(line_start),
    .ly(ly), .scy(scy), .scx(scx),
    .map_sel(map_sel), .data_sel(data_sel), .bg_en(bg_en),
    .vram_adr(vram_adr), .vram_read(vram_read),
    .vram_gnt(vram_gnt), .vram_dout(vram_dout),
    .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .line_done(line_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_read && vram_gnt) begin
      vram_dout <= mem[vram_adr];
      rd_log.push_back(vram_adr);
    end
  end

  always @(negedge clk) if (line_done) ld_cnt++;

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_pix(input int x);
    int row, bgx, ma, t, s, base, a, b;
    logic [7:0] lo, hi;
    row  = (int'(ly) + int'(scy)) & 255;
    bgx  = (int'(scx) + x) & 255;
    ma   = (map_sel ? 'h1C00 : 'h1800) + (row >> 3) * 32 + (bgx >> 3);
    t    = int'(mem[ma]);
    s    = (t >= 128) ? t - 256 : t;
    base = data_sel ? t * 16 : 'h1000 + s * 16;
    a    = (base + (row & 7) * 2) & 'h1FFF;
    lo   = mem[a];
    hi   = mem[(a + 1) & 'h1FFF];
    b    = 7 - (bgx & 7);
    return {hi[b], lo[b]};
  endfunction

  function automatic logic [12:0] exp_map();
    int row;
    row = (int'(ly) + int'(scy)) & 255;
    return 13'((map_sel ? 'h1C00 : 'h1800) + (row >> 3) * 32 + (scx >> 3));
  endfunction

  task automatic run_line(input string tag, input bit tog);
    int acc, cyc;
    bit hold;
    logic [1:0] prev, e;
    ld_cnt = 0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    rd_log.delete();
    chk({tag, " busy"}, 32'(busy), 1);
    chk({tag, " map rd"}, 32'(vram_read), 1);
    chk({tag, " map adr"}, 32'(vram_adr), 32'(exp_map()));
    chk({tag, " flushed"}, 32'(pix_valid), 0);
    acc = 0; cyc = 0; hold = 0; prev = 0; first_v = -1;
    while (acc < LP && cyc < 4000) begin
      pix_ready = tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (pix_valid && first_v < 0) first_v = cyc;
      if (hold) begin
        chk({tag, " hold valid"}, 32'(pix_valid), 1);
        chk({tag, " hold pix"}, 32'(pix), 32'(prev));
      end
      if (pix_valid && pix_ready) begin
        e = bg_zero ? 2'b00 : exp_pix(acc);
        chk($sformatf("%s pix%0d", tag, acc), 32'(pix), 32'(e));
        got[acc] = pix;
        acc++;
      end
      hold = pix_valid && !pix_ready;
      prev = pix;
      tick();
      cyc++;
    end
    chk({tag, " accepts"}, 32'(acc), LP);
    chk({tag, " done pulse"}, 32'(line_done), 1);
    chk({tag, " busy drop"}, 32'(busy), 0);
    chk({tag, " valid drop"}, 32'(pix_valid), 0);
    chk({tag, " rd drop"}, 32'(vram_read), 0);
    pix_ready = 1'b1;
    tick();
    chk({tag, " done 1cyc"}, 32'(line_done), 0);
    chk({tag, " done count"}, 32'(ld_cnt), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " rd"}, 32'(vram_read), 0);
    chk({tag, " adr"}, 32'(vram_adr), 0);
    chk({tag, " pix"}, 32'(pix), 0);
    chk({tag, " valid"}, 32'(pix_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(line_done), 0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++)
      mem[i] = 8'((i * 7) ^ (i >> 3) ^ 8'h5A);

    reset = 1'b1;
    #2;
    chk_idle("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_idle("post reset");

    // Unsigned tiles, no scroll, tile 1 is solid colour 01
    mem[13'h1800] = 8'h01;
    mem[13'h0010] = 8'hFF;
    mem[13'h0011] = 8'h00;
    ly = 0; scy = 0; scx = 0; map_sel = 0; data_sel = 1;
    run_line("basic", 1'b0);
    chk("basic rd0", 32'(rd_log[0]), 32'h1800);
    chk("basic rd1", 32'(rd_log[1]), 32'h0010);
    chk("basic rd2", 32'(rd_log[2]), 32'h0011);
    chk("basic latency", 32'(first_v), 7);
    for (int i = 0; i < 8; i++)
      chk($sformatf("basic first8 %0d", i), 32'(got[i]), 1);

    // Signed tile 0x80, row 5
    mem[13'h1800] = 8'h80;
    data_sel = 0; ly = 8'd3; scy = 8'd2;
    run_line("signed", 1'b0);
    chk("signed rd0", 32'(rd_log[0]), 32'h1800);
    chk("signed rd1", 32'(rd_log[1]), 32'h080A);
    chk("signed rd2", 32'(rd_log[2]), 32'h080B);

    // Fine scroll with map column wrap
    data_sel = 1; ly = 0; scy = 0; scx = 8'hFD;
    run_line("scroll", 1'b0);
    chk("scroll rd0", 32'(rd_log[0]), 32'h181F);
    chk("scroll rd3", 32'(rd_log[3]), 32'h1800);

    // Backpressure on alternate cycles
    map_sel = 1; ly = 8'h50; scy = 8'h40; scx = 8'h13;
    run_line("bp", 1'b1);

    // Grant stall during LO then a mid-line restart
    mem[13'h1800] = 8'h01;
    map_sel = 0; ly = 0; scy = 0; scx = 0; data_sel = 1;
    ld_cnt = 0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    vram_gnt = 1'b0;
    begin
      int n0;
      n0 = rd_log.size();
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("stall adr%0d", i), 32'(vram_adr), 32'h0010);
        chk($sformatf("stall rd%0d", i), 32'(vram_read), 1);
        tick();
      end
      chk("stall no issue", 32'(rd_log.size()), 32'(n0));
    end
    vram_gnt = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("abort busy", 32'(busy), 1);
    chk("abort no done", 32'(ld_cnt), 0);
    run_line("restart", 1'b0);

    // Asynchronous reset between edges
    scx = 8'h05;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async rst");
    @(negedge clk);
    reset = 1'b0;
    tick();

    bg_en = 1'b0;
`ifdef BG_DISABLE_EN
    bg_zero = 1'b1;
`else
    bg_zero = 1'b0;
`endif
    run_line("bgoff", 1'b0);
    chk("bgoff reads", 32'(rd_log.size() >= 60), 1);
    bg_en = 1'b1;
    bg_zero = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
